// File: rtl/stack_core_pkg.sv
// Shared definitions for the stack processor core: opcodes, FSM states, fault codes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package stack_core_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    POP_A,
    POP_B,
    PUSH_R,
    MEM_RD,
    PUSH_M,
    MEM_WR,
    TRAP
  } state_t;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OVF  = 2'b01;
  localparam logic [1:0] FAULT_UNF  = 2'b10;

  // Number of stack entries an opcode consumes; used by the DECODE stack check.
  function automatic logic [1:0] operands_needed(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND: return 2'd2;
      OP_NOT, OP_POP, OP_JZ:  return 2'd1;
      default:                return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_file.sv
// Bounded LIFO operand stack with combinational top-of-stack read.
// Latency: push/pop take effect on the next rising edge; tos/count reflect registered state.
// Backpressure: none; push while full and pop while empty are ignored (the core never issues them).
// Ports: clk, rst (async active-low, clears count only), push, pop, din -> tos (0 when empty),
//        count (occupancy), full, empty.
module stack_file #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 16,
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tos,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] entry [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  // count never exceeds STACK_DEPTH, so the narrowed indices stay in range
  // whenever they are used (write only when not full, read only when not empty).
  assign wr_idx  = IDX_W'(count);
  assign top_idx = IDX_W'(count - CNT_W'(1));

  assign full  = (count == CNT_W'(STACK_DEPTH));
  assign empty = (count == '0);
  assign tos   = empty ? '0 : entry[top_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Storage carries no reset; only the occupancy counter defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      entry[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/stack_core.sv
// Multi-cycle stack processor: FSM controller, ALU datapath and operand stack with trap on over/underflow.
// Latency (zero-wait memory): JMP/JZ 2 cycles, NOT/POP/PUSH 4, ADD/SUB/AND 5; each memory wait state adds 1.
// Backpressure: memory port is req/ack; req and its addr/we/wdata hold until ack; ack without req is ignored.
// Ports: clk, rst (async active-low); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in;
//        halted, fault (00 none, 01 overflow, 10 underflow); pc_dbg, sp_dbg, tos_dbg debug taps.
module stack_core
  import stack_core_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 16,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [1:0]        fault,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [SP_W-1:0]   sp_dbg,
  output logic [DATA_W-1:0] tos_dbg
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] mdr;

  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] tos;
  logic [DATA_W-1:0] din;
  logic [SP_W-1:0]   sp;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              xfer;
  logic              unf;
  logic              ovf;
  logic [1:0]        need;

  // Request is decoded from registered state; gating with rst makes it drop
  // the instant reset asserts, aborting any transaction in flight.
  assign mem_req   = rst && ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR));
  assign mem_we    = (state == MEM_WR);
  assign mem_addr  = (state == FETCH) ? pc : ir_addr;
  assign mem_wdata = a;
  assign xfer      = mem_req && mem_ack;

  assign push = (state == PUSH_R) || (state == PUSH_M);
  assign pop  = (state == POP_A) || (state == POP_B);
  assign din  = (state == PUSH_M) ? mdr : alu;

  stack_file #(
    .DATA_W      (DATA_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .tos   (tos),
    .count (sp),
    .full  (full),
    .empty (empty)
  );

  // A is the first popped (old top), B the one beneath it.
  always_comb begin
    alu = a + b;
    case (ir_op)
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_NOT:  alu = ~a;
      default: alu = a + b;
    endcase
  end

  always_comb begin
    need = operands_needed(ir_op);
    unf  = 1'b0;
    case (need)
      2'd2:    unf = (sp < SP_W'(2));
      2'd1:    unf = empty;
      default: unf = 1'b0;
    endcase
    ovf = (ir_op == OP_PUSH) && full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= '0;
      ir_op   <= '0;
      ir_addr <= '0;
      a       <= '0;
      b       <= '0;
      mdr     <= '0;
      halted  <= 1'b0;
      fault   <= FAULT_NONE;
    end else begin
      case (state)
        FETCH: begin
          if (xfer) begin
            ir_op   <= mem_rdata[DATA_W-1 -: 3];
            ir_addr <= mem_rdata[ADDR_W-1:0];
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (unf || ovf) begin
            // PC stays on the offending instruction for post-mortem.
            state  <= TRAP;
            halted <= 1'b1;
            fault  <= unf ? FAULT_UNF : FAULT_OVF;
          end else begin
            pc <= pc + ADDR_W'(1);
            case (ir_op)
              OP_JMP: begin
                pc    <= ir_addr;
                state <= FETCH;
              end
              OP_JZ: begin
                // Tested against TOS before any stack movement; JZ never pops.
                if (tos == '0) pc <= ir_addr;
                state <= FETCH;
              end
              OP_PUSH: state <= MEM_RD;
              default: state <= POP_A;
            endcase
          end
        end
        POP_A: begin
          a <= tos;
          if (ir_op == OP_NOT)      state <= PUSH_R;
          else if (ir_op == OP_POP) state <= MEM_WR;
          else                      state <= POP_B;
        end
        POP_B: begin
          b     <= tos;
          state <= PUSH_R;
        end
        PUSH_R: state <= FETCH;
        MEM_RD: begin
          if (xfer) begin
            mdr   <= mem_rdata;
            state <= PUSH_M;
          end
        end
        PUSH_M: state <= FETCH;
        MEM_WR: begin
          if (xfer) state <= FETCH;
        end
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  assign pc_dbg  = pc;
  assign sp_dbg  = sp;
  assign tos_dbg = tos;

endmodule

// File: tb/tb_stack_core.sv
// Self-checking bench for stack_core: behavioural memory with programmable wait states,
// a write scoreboard, a table of ALU vectors and directed jump/trap/reset sequences.
// A second instance with STACK_DEPTH=2 executes an endless stream of PUSHes to hit overflow.
module tb_stack_core;

  localparam logic [2:0] C_ADD = 3'b000, C_SUB = 3'b001, C_AND = 3'b010, C_NOT = 3'b011;
  localparam logic [2:0] C_PUSH = 3'b100, C_POP = 3'b101, C_JMP = 3'b110, C_JZ = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  always #5 clk = ~clk;

  logic       mem_req, mem_we, halted;
  logic [4:0] mem_addr, pc_dbg, sp_dbg;
  logic [7:0] mem_wdata, tos_dbg;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack = 1'b0;
  logic [1:0] fault;

  stack_core #(.DATA_W(8), .ADDR_W(5), .STACK_DEPTH(16)) u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted),
    .fault(fault), .pc_dbg(pc_dbg), .sp_dbg(sp_dbg), .tos_dbg(tos_dbg)
  );

  // Depth-2 core: every fetch and data read returns 8'h90 (PUSH 16), ack tied high.
  logic       o_req, o_we, o_halted;
  logic [4:0] o_addr, o_pc;
  logic [7:0] o_wdata, o_tos;
  logic [1:0] o_fault, o_sp;

  stack_core #(.DATA_W(8), .ADDR_W(5), .STACK_DEPTH(2)) u_ovf (
    .clk(clk), .rst(rst), .mem_req(o_req), .mem_we(o_we), .mem_addr(o_addr),
    .mem_wdata(o_wdata), .mem_rdata(8'h90), .mem_ack(1'b1), .halted(o_halted),
    .fault(o_fault), .pc_dbg(o_pc), .sp_dbg(o_sp), .tos_dbg(o_tos)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] adr);
    return {op, adr};
  endfunction

  // ---------------- memory model + scoreboard ----------------
  typedef struct packed { logic [4:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [4:0] addr; logic [4:0] sp; } rd_t;

  logic [7:0] mem [32];
  wr_t        sbq[$];
  rd_t        rd_log[$];
  int         wait_cycles = 0;
  int         wcnt = 0;
  int         cyc = 0;
  int         wr_cyc = 0;
  logic       in_txn = 1'b0;
  logic [4:0] last_addr;
  logic [7:0] last_wdata;
  logic       last_we;

  // Runs at the falling edge so the DUT's registered state is settled; the ack
  // raised here completes the transaction on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      wcnt = 0; cyc = 0; in_txn = 1'b0; mem_ack = 1'b0;
    end else begin
      cyc++;
      if (in_txn && mem_req) begin
        check("hold_addr", 32'(mem_addr), 32'(last_addr));
        check("hold_we", 32'(mem_we), 32'(last_we));
        check("hold_wdata", 32'(mem_wdata), 32'(last_wdata));
      end
      if (mem_req) begin
        if (wcnt >= wait_cycles) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wcnt      = 0;
          in_txn    = 1'b0;
          if (mem_we) begin
            wr_t e;
            mem[mem_addr] = mem_wdata;
            wr_cyc = cyc;
            if (sbq.size() == 0) begin
              check("unexpected_write", 32'(mem_addr), 32'h0000_FFFF);
            end else begin
              e = sbq.pop_front();
              check("wr_addr", 32'(mem_addr), 32'(e.addr));
              check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
          end else begin
            rd_log.push_back('{addr: mem_addr, sp: sp_dbg});
          end
        end else begin
          mem_ack    = 1'b0;
          wcnt++;
          in_txn     = 1'b1;
          last_addr  = mem_addr;
          last_we    = mem_we;
          last_wdata = mem_wdata;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
        in_txn  = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic enter_reset();
    rst = 1'b0;
    sbq.delete();
    rd_log.delete();
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
    @(posedge clk);
  endtask

  task automatic release_reset(input int w);
    wait_cycles = w;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && sbq.size() != 0; i++) @(posedge clk);
    check(name, 32'(sbq.size()), 0);
  endtask

  task automatic load_add_prog();
    mem[0] = ins(C_PUSH, 5'd10); mem[1] = ins(C_PUSH, 5'd11);
    mem[2] = ins(C_ADD, 5'd0);   mem[3] = ins(C_POP, 5'd12);
    mem[4] = ins(C_JMP, 5'd4);
    mem[10] = 8'd3; mem[11] = 8'd5;
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] first;   // pushed first -> becomes B
    logic [7:0] second;  // pushed second -> becomes A
    logic [7:0] res;
    logic [7:0] tos;
    logic [4:0] sp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{C_ADD, 8'h03, 8'h05, 8'h08, 8'h00, 5'd0};
    vecs[1] = '{C_SUB, 8'h03, 8'h05, 8'h02, 8'h00, 5'd0};
    vecs[2] = '{C_SUB, 8'h05, 8'h03, 8'hFE, 8'h00, 5'd0};
    vecs[3] = '{C_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'd0};
    vecs[4] = '{C_NOT, 8'h55, 8'h0F, 8'hF0, 8'h55, 5'd1};
    vecs[5] = '{C_ADD, 8'hFF, 8'h02, 8'h01, 8'h00, 5'd0};
    vecs[6] = '{C_AND, 8'hAA, 8'h55, 8'h00, 8'h00, 5'd0};

    // ---- reset state ----
    enter_reset();
    @(negedge clk); #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_pc", 32'(pc_dbg), 0);
    check("rst_sp", 32'(sp_dbg), 0);
    check("rst_tos", 32'(tos_dbg), 0);
    check("rst_ovf_req", 32'(o_req), 0);

    // ---- PUSH/PUSH/ADD/POP, zero wait ----
    load_add_prog();
    sbq.push_back('{addr: 5'd12, data: 8'd8});
    release_reset(0);
    @(negedge clk); #1;
    check("first_fetch_req", 32'(mem_req), 1);
    check("first_fetch_addr", 32'(mem_addr), 0);
    drain("add_drain", 100);
    repeat (3) @(negedge clk); #1;
    check("add_cycles", 32'(wr_cyc), 17);
    check("add_sp", 32'(sp_dbg), 0);
    check("add_halted", 32'(halted), 0);
    // depth-2 core has had plenty of time to trap on its third PUSH
    check("ovf_fault", 32'(o_fault), 1);
    check("ovf_halted", 32'(o_halted), 1);
    check("ovf_sp", 32'(o_sp), 2);
    check("ovf_pc", 32'(o_pc), 2);
    check("ovf_no_req", 32'(o_req), 0);

    // ---- same program, 3 wait states on every transaction ----
    enter_reset();
    load_add_prog();
    sbq.push_back('{addr: 5'd12, data: 8'd8});
    release_reset(3);
    drain("wait_drain", 200);
    repeat (3) @(negedge clk); #1;
    check("wait_cycles", 32'(wr_cyc), 38);
    check("wait_sp", 32'(sp_dbg), 0);

    // ---- reset asserted mid-wait ----
    enter_reset();
    load_add_prog();
    release_reset(3);
    @(posedge clk); #2;
    check("midwait_req", 32'(mem_req), 1);
    rst = 1'b0;
    #1;
    check("abort_req", 32'(mem_req), 0);
    check("abort_pc", 32'(pc_dbg), 0);
    @(posedge clk); #1;
    sbq.push_back('{addr: 5'd12, data: 8'd8});
    rst = 1'b1;
    @(negedge clk); #1;
    check("refetch_req", 32'(mem_req), 1);
    check("refetch_addr", 32'(mem_addr), 0);
    drain("refetch_drain", 200);

    // ---- ALU vector table ----
    for (int i = 0; i < 7; i++) begin
      enter_reset();
      mem[0] = ins(C_PUSH, 5'd16); mem[1] = ins(C_PUSH, 5'd17);
      mem[2] = ins(vecs[i].op, 5'd0); mem[3] = ins(C_POP, 5'd18);
      mem[4] = ins(C_JMP, 5'd4);
      mem[16] = vecs[i].first; mem[17] = vecs[i].second;
      sbq.push_back('{addr: 5'd18, data: vecs[i].res});
      release_reset(i % 3);
      drain("alu_drain", 200);
      repeat (3) @(negedge clk); #1;
      check("alu_sp", 32'(sp_dbg), 32'(vecs[i].sp));
      check("alu_tos", 32'(tos_dbg), 32'(vecs[i].tos));
      check("alu_fault", 32'(fault), 0);
    end

    // ---- JZ taken / not taken ----
    for (int c = 0; c < 2; c++) begin
      logic [4:0] nxt_addr;
      logic [4:0] nxt_sp;
      int         idx;
      enter_reset();
      mem[0] = ins(C_PUSH, 5'd16); mem[1] = ins(C_JMP, 5'd4);
      mem[4] = ins(C_JZ, 5'd9);
      mem[5] = ins(C_POP, 5'd19);  mem[6] = ins(C_JMP, 5'd6);
      mem[9] = ins(C_POP, 5'd18);  mem[10] = ins(C_JMP, 5'd10);
      mem[16] = 8'(c);
      if (c == 0) sbq.push_back('{addr: 5'd18, data: 8'd0});
      else        sbq.push_back('{addr: 5'd19, data: 8'd1});
      release_reset(0);
      drain("jz_drain", 100);
      nxt_addr = 'x;
      nxt_sp   = 'x;
      idx      = -1;
      for (int k = 0; k < rd_log.size(); k++) begin
        if (idx < 0 && rd_log[k].addr == 5'd4) idx = k;
      end
      if (idx >= 0 && idx + 1 < rd_log.size()) begin
        nxt_addr = rd_log[idx+1].addr;
        nxt_sp   = rd_log[idx+1].sp;
      end
      check("jz_next_fetch", 32'(nxt_addr), (c == 0) ? 9 : 5);
      check("jz_sp_kept", 32'(nxt_sp), 1);
    end

    // ---- underflow: ADD with one entry ----
    begin
      int reqs;
      enter_reset();
      mem[0] = ins(C_PUSH, 5'd16); mem[1] = ins(C_ADD, 5'd0);
      mem[16] = 8'h07;
      release_reset(0);
      repeat (6) @(negedge clk); #1;
      check("unf_pre_halted", 32'(halted), 0);
      @(negedge clk); #1;
      check("unf_halted", 32'(halted), 1);
      check("unf_fault", 32'(fault), 2);
      check("unf_pc", 32'(pc_dbg), 1);
      check("unf_sp", 32'(sp_dbg), 1);
      check("unf_tos", 32'(tos_dbg), 7);
      reqs = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk); #1;
        if (mem_req) reqs++;
      end
      check("unf_no_req", 32'(reqs), 0);
      check("unf_fault_held", 32'(fault), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_core.md
# stack_core

Parametrised multi-cycle stack processor core: the controller FSM, datapath, and a bounded operand stack in one block. It replaces the fixed 8-bit/5-bit datapath-plus-external-controller split. Generalisations over the previous generation:
- configurable data width, address width and stack depth;
- handshaked external memory port;
- stack overflow/underflow trapping;
- debug visibility.

It sits between the instruction/data memory and the system top.

## Interface
Parameters:
- DATA_W, 8, data and instruction word width; must satisfy DATA_W >= ADDR_W+3
- ADDR_W, 5, memory address width; also PC width
- STACK_DEPTH, 16, operand stack entries; must be >= 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  transaction address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data; sampled on the edge where mem_ack=1
- mem_ack  in  1  transaction completes on the rising edge where mem_req=1 and mem_ack=1
- halted  out  1  core stopped in TRAP
- fault  out  2  00 none, 01 overflow, 10 underflow
- pc_dbg  out  ADDR_W  current PC
- sp_dbg  out  $clog2(STACK_DEPTH+1)  stack occupancy
- tos_dbg  out  DATA_W  top-of-stack entry; 0 when empty

## Operation
- Instruction format:
  - opcode = inst[DATA_W-1:DATA_W-3]
  - operand address = inst[ADDR_W-1:0]
  - remaining bits are ignored.
- Opcodes (A = first popped/top, B = second popped):
  - 000 ADD: push A+B
  - 001 SUB: push A−B
  - 010 AND: push A&B
  - 011 NOT: push ~A
  - 100 PUSH addr: push mem[addr]
  - 101 POP addr: mem[addr] ← A
  - 110 JMP addr: PC ← addr
  - 111 JZ addr: PC ← addr if TOS==0; TOS is not popped
- Arithmetic is modulo 2^DATA_W; no flags.
- PC increments modulo 2^ADDR_W, so PC wraps from all-ones to 0.
- States and transitions:
  - FETCH: mem_req=1, we=0, addr=PC. Wait for ack, then IR ← rdata and go to DECODE.
  - DECODE: run the stack check:
    - underflow if sp < operands needed (ADD/SUB/AND: 2; NOT/POP/JZ: 1);
    - overflow if PUSH and sp==STACK_DEPTH.
    - On a failed check go to TRAP; PC is not incremented.
    - Otherwise PC ← PC+1 (or the jump target), then route:
      - JMP/JZ → FETCH
      - ADD/SUB/AND/NOT/POP → POP_A
      - PUSH → MEM_RD
  - POP_A: A ← TOS, sp−1. Next state: NOT → PUSH_R; POP → MEM_WR; binary ops → POP_B.
  - POP_B: B ← TOS, sp−1, go to PUSH_R.
  - PUSH_R: push ALU result, go to FETCH.
  - MEM_RD: read at operand addr; on ack latch MDR and go to PUSH_M.
  - PUSH_M: push MDR, go to FETCH.
  - MEM_WR: write A to operand addr; on ack go to FETCH.
  - TRAP: halted=1, fault held, no memory requests, no state change; left only by reset.
- JZ evaluates TOS before any stack change in DECODE.

## Timing
- Reset (asynchronous assert): PC=0, sp=0, state=FETCH, IR=A=B=MDR=0, halted=0, fault=00, mem_req=0. Stack contents are not reset.
- mem_req is registered-state-decoded. It is high in the first FETCH cycle after reset deasserts.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 until ack.
  - mem_ack may be high in the same cycle as the request, giving a zero-wait transaction of one cycle.
  - mem_ack while mem_req=0 is ignored.
  - Each wait state adds one cycle.
- Zero-wait instruction latency, in cycles:
  - JMP/JZ: 2
  - NOT/POP/PUSH: 4
  - ADD/SUB/AND: 5
- Trap is entered on the edge ending DECODE. halted and fault are visible the following cycle.
- Reset asserted mid-transaction aborts it immediately; mem_req drops asynchronously.

## Structure
- Package stack_core_pkg holds:
  - opcode localparams;
  - state enum (FETCH, DECODE, POP_A, POP_B, PUSH_R, MEM_RD, PUSH_M, MEM_WR, TRAP);
  - fault codes.
- Sub-module stack_file(DATA_W, STACK_DEPTH):
  - ports: push, pop, din, tos, count, full, empty;
  - asynchronous active-low reset clears count only;
  - push while full and pop while empty are ignored, since the core prevents them.

## Test plan
- Default params, zero-wait memory: program PUSH 10 (mem[10]=3), PUSH 11 (mem[11]=5), ADD, POP 12 → mem[12]=8; sp=0; 4+4+5+4=17 cycles from reset release to the write ack.
- SUB ordering: push 3, then push 5, SUB → result 5−3=2; NOT of 8'h0F → 8'hF0.
- JZ: TOS=0 at PC=4, target 9 → next fetch address 9, sp unchanged; TOS=1 → next fetch address 5.
- Underflow: ADD with sp=1 → fault=10, halted=1, pc_dbg=address of the ADD, no further mem_req.
- Overflow: STACK_DEPTH=2, three PUSHes → fault=01 on the third; sp_dbg=2.
- Wait states: ack delayed 3 cycles on every transaction → same results, with mem_addr/mem_wdata held stable throughout. Reset asserted mid-wait → mem_req=0 immediately; refetch from PC 0.
